// File: rtl/tot_window_multi.sv
// -----------------------------------------------------------------------------
// tot_window_multi
//   Multi-channel sliding-window time-over-threshold accumulator. For each of
//   NCH synchronised discriminator inputs it reports how many of the last Weff
//   captured samples were high, where Weff = max(WINDOW, 2).
//
//   Pipeline: SIGNAL is captured into sig_q (edge k). At edge k+1 it is written
//   into the delay line while the sample written Weff writes earlier is read
//   out. At edge k+2 the counts, OVER, PEAK and VALID update together.
//
// Ports
//   CLK        system clock
//   RESET      synchronous, active-low reset
//   ENABLE     run control; low returns to IDLE with counts cleared
//   SIGNAL     [NCH]          discriminator inputs, bit i = channel i
//   WINDOW     [DEPTH_LOG2]   window length (0 and 1 behave as 2)
//   THRESHOLD  [CNT_W]        level for OVER, shared by all channels
//   PEAK_CLR   pulse, reloads every PEAK with the new count
//   TOT_OUT    [NCH*CNT_W]    per-channel count, channel i at [i*CNT_W +: CNT_W]
//   OVER       [NCH]          per-channel TOT_OUT >= THRESHOLD (0 when !VALID)
//   PEAK       [NCH*CNT_W]    per-channel maximum TOT_OUT since last clear
//   VALID      counts cover a full window
// -----------------------------------------------------------------------------
module tot_window_multi #(
  parameter int NCH        = 4,
  parameter int DEPTH_LOG2 = 12,
  parameter int CNT_W      = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    ENABLE,
  input  logic [NCH-1:0]          SIGNAL,
  input  logic [DEPTH_LOG2-1:0]   WINDOW,
  input  logic [CNT_W-1:0]        THRESHOLD,
  input  logic                    PEAK_CLR,
  output logic [NCH*CNT_W-1:0]    TOT_OUT,
  output logic [NCH-1:0]          OVER,
  output logic [NCH*CNT_W-1:0]    PEAK,
  output logic                    VALID
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_RUN = 2'd2} state_t;
  // Operation applied to the counts one edge after a sample is written.
  typedef enum logic [1:0] {OP_NONE = 2'd0, OP_FILL = 2'd1, OP_FILL_LAST = 2'd2, OP_RUN = 2'd3} op_t;

  state_t                        state_q, state_d;
  op_t                           op_q, op_d;
  logic [DEPTH_LOG2-1:0]         fill_q, fill_d;
  logic [DEPTH_LOG2-1:0]         wptr_q;
  logic [DEPTH_LOG2-1:0]         win_q;
  logic [DEPTH_LOG2-1:0]         weff_s;
  logic [DEPTH_LOG2-1:0]         rd_addr_s;
  logic                          win_chg_s;
  logic                          we_s;
  logic                          clr_s;
  logic [NCH-1:0]                sig_q, new_q, old_q;
  logic [NCH-1:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic [NCH-1:0][CNT_W-1:0]     peak_q, peak_d;
  logic [NCH-1:0]                over_q, over_d;
  logic                          valid_q, valid_d;
  logic [NCH-1:0]                mem_q [0:(1<<DEPTH_LOG2)-1];

  // Effective window, read address and window-change detect.
  always_comb begin
    if (win_q < DEPTH_LOG2'(2)) begin
      weff_s = DEPTH_LOG2'(2);
    end else begin
      weff_s = win_q;
    end
    rd_addr_s = wptr_q - weff_s;
    win_chg_s = (WINDOW != win_q);
  end

  // FSM state, fill counter and write pointer registers.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      fill_q  <= '0;
      wptr_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      if (we_s) begin
        wptr_q <= wptr_q + DEPTH_LOG2'(1);
      end else begin
        wptr_q <= wptr_q;
      end
    end
  end

  // FSM next state: decides per sample whether it fills, runs or is dropped.
  // A restart (disable or window change) drops the sample on that edge and
  // clears the counts immediately, so stale delay-line data is never used.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    op_d    = OP_NONE;
    we_s    = 1'b0;
    clr_s   = 1'b0;
    if (!ENABLE) begin
      state_d = S_IDLE;
      fill_d  = '0;
      clr_s   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_FILL;
          fill_d  = '0;
        end
        S_FILL: begin
          if (win_chg_s) begin
            state_d = S_FILL;
            fill_d  = '0;
            clr_s   = 1'b1;
          end else begin
            we_s = 1'b1;
            if (fill_q == weff_s - DEPTH_LOG2'(1)) begin
              op_d    = OP_FILL_LAST;
              state_d = S_RUN;
              fill_d  = '0;
            end else begin
              op_d   = OP_FILL;
              fill_d = fill_q + DEPTH_LOG2'(1);
            end
          end
        end
        S_RUN: begin
          if (win_chg_s) begin
            state_d = S_FILL;
            fill_d  = '0;
            clr_s   = 1'b1;
          end else begin
            we_s = 1'b1;
            op_d = OP_RUN;
          end
        end
        default: begin
          state_d = S_IDLE;
          fill_d  = '0;
          clr_s   = 1'b1;
        end
      endcase
    end
  end

  // Delay line: one NCH-wide word per sample, registered read.
  always_ff @(posedge CLK) begin
    if (we_s) begin
      mem_q[wptr_q] <= sig_q;
    end
    old_q <= mem_q[rd_addr_s];
  end

  // Next counts, flags and peaks for every channel.
  always_comb begin
    valid_d = !clr_s && ((op_q == OP_FILL_LAST) || (op_q == OP_RUN));
    cnt_d   = '0;
    over_d  = '0;
    peak_d  = peak_q;
    for (int i = 0; i < NCH; i++) begin
      if (clr_s) begin
        cnt_d[i] = '0;
      end else begin
        case (op_q)
          OP_FILL, OP_FILL_LAST: cnt_d[i] = cnt_q[i] + CNT_W'(new_q[i]);
          OP_RUN:                cnt_d[i] = cnt_q[i] + CNT_W'(new_q[i]) - CNT_W'(old_q[i]);
          default:               cnt_d[i] = '0;
        endcase
      end
      over_d[i] = valid_d && (cnt_d[i] >= THRESHOLD);
      if (PEAK_CLR) begin
        peak_d[i] = valid_d ? cnt_d[i] : '0;
      end else if (valid_d && (cnt_d[i] > peak_q[i])) begin
        peak_d[i] = cnt_d[i];
      end else begin
        peak_d[i] = peak_q[i];
      end
    end
  end

  // Input capture, sample pipeline and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      sig_q   <= '0;
      new_q   <= '0;
      win_q   <= '0;
      op_q    <= OP_NONE;
      cnt_q   <= '0;
      over_q  <= '0;
      peak_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sig_q   <= SIGNAL;
      new_q   <= sig_q;
      win_q   <= WINDOW;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      over_q  <= over_d;
      peak_q  <= peak_d;
      valid_q <= valid_d;
    end
  end

  assign TOT_OUT = cnt_q;
  assign PEAK    = peak_q;
  assign OVER    = over_q;
  assign VALID   = valid_q;

endmodule

// File: tb/tb_tot_window_multi.sv
// -----------------------------------------------------------------------------
// tb_tot_window_multi
//   Directed self-checking bench for tot_window_multi (NCH=4, DEPTH_LOG2=12,
//   CNT_W=16). Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_tot_window_multi;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic [3:0]  SIGNAL;
  logic [11:0] WINDOW;
  logic [15:0] THRESHOLD;
  logic        PEAK_CLR;
  logic [63:0] TOT_OUT;
  logic [3:0]  OVER;
  logic [63:0] PEAK;
  logic        VALID;

  int n_checks = 0;
  int n_errors = 0;
  logic tog = 1'b0;

  tot_window_multi #(.NCH(4), .DEPTH_LOG2(12), .CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .SIGNAL(SIGNAL),
    .WINDOW(WINDOW), .THRESHOLD(THRESHOLD), .PEAK_CLR(PEAK_CLR),
    .TOT_OUT(TOT_OUT), .OVER(OVER), .PEAK(PEAK), .VALID(VALID)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
    if (tog) SIGNAL[1] = ~SIGNAL[1];
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all4(input int v);
    logic [15:0] w;
    w = 16'(v);
    return {w, w, w, w};
  endfunction

  // Ones in [1,plen] intersected with the window [n-1-w, n-2].
  function automatic int win_ones(input int n, input int plen, input int w);
    int c;
    c = 0;
    for (int k = 1; k <= plen; k++) begin
      if ((k >= n - 1 - w) && (k <= n - 2)) c++;
    end
    return c;
  endfunction

  initial begin
    int e;
    int pk;
    RESET = 1'b0; ENABLE = 1'b0; SIGNAL = 4'h0; WINDOW = 12'd10;
    THRESHOLD = 16'd5; PEAK_CLR = 1'b0;
    tick(); tick();
    chk("rst_tot", TOT_OUT, 64'd0);
    chk("rst_peak", PEAK, 64'd0);
    chk("rst_over", {60'd0, OVER}, 64'd0);
    chk("rst_valid", {63'd0, VALID}, 64'd0);

    // Fill ramp with all channels high, WINDOW=10.
    RESET = 1'b1; ENABLE = 1'b1; SIGNAL = 4'hF;
    tick(); tick();
    for (int j = 1; j <= 10; j++) begin
      tick();
      chk("ramp_tot", TOT_OUT, all4(j));
      chk("ramp_valid", {63'd0, VALID}, {63'd0, (j == 10)});
    end
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("full_tot", TOT_OUT, all4(10));
    end
    chk("full_over", {60'd0, OVER}, 64'hF);
    chk("full_peak", PEAK, all4(10));

    // One-cycle reset mid-run, then refill.
    RESET = 1'b0;
    tick();
    chk("mrst_tot", TOT_OUT, 64'd0);
    chk("mrst_peak", PEAK, 64'd0);
    chk("mrst_vo", {59'd0, OVER, VALID}, 64'd0);
    RESET = 1'b1;
    tick(); tick(); tick();
    chk("refill1", TOT_OUT, all4(1));
    for (int j = 0; j < 9; j++) tick();
    chk("refill10", TOT_OUT, all4(10));
    chk("refill_valid", {63'd0, VALID}, 64'd1);

    // Disable: counts clear, PEAK held.
    ENABLE = 1'b0;
    tick();
    chk("dis_tot", TOT_OUT, 64'd0);
    chk("dis_vo", {59'd0, OVER, VALID}, 64'd0);
    chk("dis_peak", PEAK, all4(10));

    // WINDOW=0 behaves as 2.
    WINDOW = 12'd0; ENABLE = 1'b1;
    tick(); tick(); tick();
    chk("w0_1", TOT_OUT, all4(1));
    chk("w0_v1", {63'd0, VALID}, 64'd0);
    tick();
    chk("w0_2", TOT_OUT, all4(2));
    chk("w0_v2", {63'd0, VALID}, 64'd1);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("w0_hold", TOT_OUT, all4(2));
    end

    // Isolated 7-cycle pulse on ch0, WINDOW=100.
    WINDOW = 12'd100; SIGNAL = 4'h0;
    tick();
    chk("w100_clr", TOT_OUT, 64'd0);
    chk("w100_v", {63'd0, VALID}, 64'd0);
    for (int j = 0; j < 110; j++) tick();
    chk("w100_run", {63'd0, VALID}, 64'd1);
    chk("w100_zero", TOT_OUT, 64'd0);
    for (int n = 1; n <= 110; n++) begin
      SIGNAL = (n <= 7) ? 4'b0001 : 4'b0000;
      tick();
      e = win_ones(n, 7, 100);
      chk("pulse_tot", TOT_OUT, {48'd0, 16'(e)});
      chk("pulse_over", {60'd0, OVER}, {63'd0, (e >= 5)});
    end

    // Window change 50 -> 20 with ch1 toggling.
    SIGNAL = 4'h0; WINDOW = 12'd50; tog = 1'b1;
    for (int j = 0; j < 60; j++) tick();
    chk("w50_tot", TOT_OUT, {32'd0, 16'd25, 16'd0});
    WINDOW = 12'd20;
    tick();
    chk("wchg_tot", TOT_OUT, 64'd0);
    chk("wchg_v", {63'd0, VALID}, 64'd0);
    for (int j = 0; j < 20; j++) tick();
    chk("w20_v0", {63'd0, VALID}, 64'd0);
    tick();
    chk("w20_v1", {63'd0, VALID}, 64'd1);
    chk("w20_tot", TOT_OUT, {32'd0, 16'd10, 16'd0});
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("w20_hold", TOT_OUT, {32'd0, 16'd10, 16'd0});
    end

    // Threshold and peak on ch2, WINDOW=16.
    tog = 1'b0; SIGNAL = 4'h0; WINDOW = 12'd16;
    for (int j = 0; j < 26; j++) tick();
    PEAK_CLR = 1'b1;
    tick();
    PEAK_CLR = 1'b0;
    chk("pclr_peak", PEAK, 64'd0);
    chk("pclr_tot", TOT_OUT, 64'd0);
    pk = 0;
    for (int n = 1; n <= 30; n++) begin
      SIGNAL = (n <= 8) ? 4'b0100 : 4'b0000;
      PEAK_CLR = (n == 23);
      tick();
      e = win_ones(n, 8, 16);
      if (n == 23) pk = e;
      else if (e > pk) pk = e;
      chk("burst_tot", TOT_OUT, {16'd0, 16'(e), 32'd0});
      chk("burst_over", {60'd0, OVER}, {61'd0, (e >= 5), 2'b00});
      chk("burst_peak", PEAK, {16'd0, 16'(pk), 32'd0});
    end
    PEAK_CLR = 1'b0;

    // WINDOW=4095 with constant ones; pointer wraps during run.
    SIGNAL = 4'hF; WINDOW = 12'd4095;
    tick();
    chk("w4095_clr", TOT_OUT, 64'd0);
    for (int t = 2; t <= 4097; t++) begin
      tick();
      if (t == 4096) begin
        chk("w4095_4094", TOT_OUT, all4(4094));
        chk("w4095_v0", {63'd0, VALID}, 64'd0);
      end
    end
    chk("w4095_full", TOT_OUT, all4(4095));
    chk("w4095_v1", {63'd0, VALID}, 64'd1);
    for (int j = 0; j < 300; j++) begin
      tick();
      chk("w4095_hold", TOT_OUT, all4(4095));
    end
    chk("w4095_peak", PEAK, all4(4095));
    chk("w4095_over", {60'd0, OVER}, 64'hF);
    THRESHOLD = 16'hFFFF;
    tick();
    chk("thr_hi_over", {60'd0, OVER}, 64'h0);
    chk("thr_hi_v", {63'd0, VALID}, 64'd1);
    THRESHOLD = 16'd4095;
    tick();
    chk("thr_eq_over", {60'd0, OVER}, 64'hF);
    chk("thr_eq_tot", TOT_OUT, all4(4095));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
